// File: rtl/nlf_enum_if.sv
// Handshake and status bundle for the non-linear filter inverse enumerator.
// The master drives the requests and the slave (the enumerator) drives the results.
interface nlf_enum_if #(
    parameter int unsigned NIN = 4
) ();
    localparam int unsigned PW = NIN + 1;

    logic          START;
    logic          BIT;
    logic          ABORT;
    logic          OUT_READY;
    logic          OUT_VALID;
    logic [NIN-1:0] OUTPUT;
    logic          LAST;
    logic [PW-1:0] COUNT;
    logic          BUSY;
    logic          DONE;

    modport master (
        output START, BIT, ABORT, OUT_READY,
        input  OUT_VALID, OUTPUT, LAST, COUNT, BUSY, DONE
    );

    modport slave (
        input  START, BIT, ABORT, OUT_READY,
        output OUT_VALID, OUTPUT, LAST, COUNT, BUSY, DONE
    );
endinterface

// File: rtl/nlf_enum.sv
// Inverse enumerator: streams every input vector x with FN[x] == latched BIT,
// in ascending order, one per accepted handshake; restartable and abortable.
module nlf_enum #(
    parameter int unsigned            NIN = 4,
    parameter logic [(1<<NIN)-1:0]    FN  = 16'h9E98
) (
    input  logic       CLK,
    input  logic       RESETn,
    nlf_enum_if.slave  bus
);
    localparam int unsigned N  = 1 << NIN;
    localparam int unsigned PW = NIN + 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH} state_e;

    function automatic logic [N-1:0] match_mask(input logic b);
        return b ? FN : ~FN;
    endfunction

    // {found, index} of the lowest set bit of m at or above from
    function automatic logic [PW:0] first_from(input logic [N-1:0] m, input logic [PW-1:0] from);
        logic [PW:0] r;
        r = '0;
        for (int j = int'(N) - 1; j >= 0; j--) begin
            if (m[j] && (PW'(j) >= from)) r = {1'b1, PW'(j)};
        end
        return r;
    endfunction

    function automatic logic any_from(input logic [N-1:0] m, input logic [PW-1:0] from);
        logic r;
        r = 1'b0;
        for (int j = 0; j < int'(N); j++) begin
            if (m[j] && (PW'(j) >= from)) r = 1'b1;
        end
        return r;
    endfunction

    function automatic int unsigned ones_in(input logic [N-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < int'(N); i++) c += 32'(v[i]);
        return c;
    endfunction

    localparam int unsigned ONES = ones_in(FN);

    state_e         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic           bit_q, bit_d;
    logic           valid_q, valid_d;
    logic [NIN-1:0] out_q, out_d;
    logic           last_q, last_d;
    logic [PW-1:0]  count_q, count_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [N-1:0]   mask_c;
    logic [PW-1:0]  from_c;
    logic [PW:0]    hit_c;
    logic [PW-1:0]  after_c;
    logic           more_c;

    // In IDLE the search uses the incoming BIT from index 0; in SCAN the latched bit from ptr
    always_comb begin
        mask_c  = match_mask((state_q == S_IDLE) ? bus.BIT : bit_q);
        from_c  = (state_q == S_IDLE) ? '0 : ptr_q;
        hit_c   = first_from(mask_c, from_c);
        after_c = hit_c[PW-1:0] + PW'(1);
        more_c  = any_from(mask_c, after_c);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bit_d   = bit_q;
        valid_d = valid_q;
        out_d   = out_q;
        last_d  = last_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    bit_d   = bus.BIT;
                    count_d = bus.BIT ? PW'(ONES) : PW'(N - ONES);
                    if (hit_c[PW]) begin
                        out_d   = hit_c[NIN-1:0];
                        ptr_d   = after_c;
                        last_d  = !more_c;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_SCAN;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end

            S_SCAN: begin
                if (bus.ABORT) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    ptr_d   = '0;
                    state_d = S_IDLE;
                end else if (valid_q && bus.OUT_READY) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        ptr_d   = '0;
                        state_d = S_FLUSH;
                    end else if (hit_c[PW]) begin
                        out_d   = hit_c[NIN-1:0];
                        ptr_d   = after_c;
                        last_d  = !more_c;
                    end
                end
            end

            S_FLUSH: begin
                busy_d  = 1'b0;
                ptr_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            last_q  <= last_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.OUT_VALID = valid_q;
    assign bus.OUTPUT    = out_q;
    assign bus.LAST      = last_q;
    assign bus.COUNT     = count_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
endmodule

// File: doc/nlf_enum.md
Name: nlf_enum

Overview:
- Parametrised inverse enumerator for an NIN-input, 1-output non-linear filter function with truth table FN.
- On a START request it latches the target output bit, then streams every input vector x with FN[x] == BIT in ascending order over a valid/ready handshake, one per cycle.
- It sits between the Crypto1 keystream-bit source and the state-recovery search. It replaces fixed 4-input, free-running enumerators with a bounded, flow-controlled, restartable sequence.

Parameters:
- NIN, 4, number of function inputs; legal range 2..8.
- FN, 16'h9E98, truth table of width 2**NIN; bit i is f(i).

Ports:
- CLK  in  1  clock
- RESETn  in  1  asynchronous active-low reset
- START  in  1  begin an enumeration; sampled only while BUSY=0
- BIT  in  1  target function output; latched on an accepted START
- ABORT  in  1  synchronous cancel; returns to IDLE next cycle
- OUT_VALID  out  1  OUTPUT/LAST hold a valid preimage
- OUT_READY  in  1  consumer accepts the current preimage
- OUTPUT  out  NIN  preimage x with FN[x] == latched BIT
- LAST  out  1  qualifies OUTPUT as the final preimage of the run
- COUNT  out  NIN+1  number of preimages for the latched BIT; popcount(FN) or 2**NIN - popcount(FN)
- BUSY  out  1  enumeration in progress
- DONE  out  1  one-cycle pulse when a run completes (not on ABORT)

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE, ptr=0, bit_q=0. OUT_VALID=0, OUTPUT=0, LAST=0, COUNT=0, BUSY=0, DONE=0.
- States: IDLE, SCAN, FLUSH.
- IDLE:
  - START=1 latches bit_q=BIT and sets COUNT for that bit.
  - match mask m[i] = (FN[i] == bit_q) over all i; the start-cycle first match uses BIT directly.
  - If m has a set bit: load the lowest set index into OUTPUT, OUT_VALID=1, ptr = that index+1, BUSY=1, go to SCAN. First preimage is visible the cycle after START (latency 1).
  - If m is empty (FN constant): COUNT=0, DONE pulses the cycle after START, no OUT_VALID, stay in IDLE, BUSY stays 0.
- SCAN: next = lowest index j >= ptr with m[j]=1 (priority encoder over the masked range).
  - On handshake (OUT_VALID & OUT_READY) with next existing: OUTPUT=next, ptr=next+1, OUT_VALID stays 1. Throughput 1 preimage/cycle.
  - LAST=1 whenever the presented OUTPUT has no further match above it. LAST is computed when OUTPUT is loaded.
  - Handshake while LAST=1: OUT_VALID=0, LAST=0, go to FLUSH.
  - OUT_VALID=1 and OUT_READY=0: OUTPUT and LAST hold stable; ptr does not advance.
- FLUSH: DONE=1 for exactly one cycle, BUSY=0, ptr=0, go to IDLE. START is ignored in FLUSH.
- START while BUSY=1 is ignored; bit_q and the sequence are unaffected.
- ABORT=1 in SCAN or FLUSH: next cycle state=IDLE, OUT_VALID=0, LAST=0, BUSY=0, DONE=0. A handshake in the same cycle as ABORT is still considered consumed. ABORT has priority over START. COUNT holds its last value.
- ptr is NIN+1 bits wide so index 2**NIN-1 does not wrap. A preimage at 2**NIN-1 is always LAST.
- OUTPUT holds its last value after a run; it is meaningful only with OUT_VALID.
- Async reset mid-run: immediate return to reset values, no DONE.

Test Plan:
- Default params, BIT=0, OUT_READY=1 → OUTPUT 0,1,2,5,6,8,13,14 on consecutive cycles; LAST only with 14; COUNT=8; DONE pulses the cycle after 14 is accepted.
- BIT=1, OUT_READY toggled 1,0,1,0 → 3,4,7,9,10,11,12,15 in order; each value holds while OUT_READY=0; LAST with 15.
- START pulsed with BIT=1 while BUSY during a BIT=0 run → sequence continues as 0,1,2,5,6,8,13,14, unaffected.
- ABORT asserted after the 3rd handshake of a BIT=0 run → OUT_VALID=0 next cycle, no DONE. A following START with BIT=1 yields 3 first.
- NIN=2, FN=4'h0, BIT=1 → COUNT=0, DONE pulses 1 cycle after START, OUT_VALID never asserts. Same FN, BIT=0 → 0,1,2,3 with LAST on 3.
- RESETn dropped mid-run with OUT_VALID=1 → OUT_VALID, BUSY, LAST, DONE go to 0 immediately without waiting for a clock edge.
